// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the program counter, drives the
// combinational-read program memory and holds each fetched word in a
// one-entry valid/ready output register towards decode.
module fetch_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic [ADDR_W-1:0]  end_addr,
    input  logic               halt_req,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  pm_addr,
    input  logic [INSTR_W-1:0] pm_data,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [INSTR_W-1:0] ins_data,
    output logic [ADDR_W-1:0]  ins_pc,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_e;

    localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e               state_q;
    logic [ADDR_W-1:0]    pc_q;
    logic                 ins_valid_q;
    logic [INSTR_W-1:0]   ins_data_q;
    logic [ADDR_W-1:0]    ins_pc_q;
    logic                 slot_free;
    logic                 in_flight;

    // Output register can take a new word if empty or being consumed now.
    assign slot_free = !ins_valid_q || ins_ready;
    // Branches are only honoured while a program is running.
    assign in_flight = (state_q == StFetch) || (state_q == StDrain);

    assign pm_addr   = pc_q;
    assign ins_valid = ins_valid_q;
    assign ins_data  = ins_data_q;
    assign ins_pc    = ins_pc_q;
    assign busy      = in_flight;
    assign done      = (state_q == StDone);

    // Sequencer FSM; priority is halt > branch > fetch/drain > start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            ins_valid_q <= 1'b0;
            ins_data_q  <= '0;
            ins_pc_q    <= '0;
        end else if (halt_req) begin
            state_q     <= StIdle;
            ins_valid_q <= 1'b0;
        end else if (br_valid && in_flight) begin
            // Squash the word in the output register; nothing captured this cycle.
            state_q     <= StFetch;
            pc_q        <= br_target;
            ins_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StFetch;
                        pc_q    <= start_addr;
                    end
                end
                StFetch: begin
                    if (slot_free) begin
                        ins_data_q  <= pm_data;
                        ins_pc_q    <= pc_q;
                        ins_valid_q <= 1'b1;
                        if (pc_q == end_addr) begin
                            state_q <= StDrain;
                        end else begin
                            pc_q <= pc_q + PcOne;
                        end
                    end
                end
                StDrain: begin
                    if (ins_valid_q && ins_ready) begin
                        ins_valid_q <= 1'b0;
                        state_q     <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a cycle model derived from the
// behavioural rules, checked every cycle, plus literal beat lists per test.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  start_addr = '0;
    logic [4:0]  end_addr = '0;
    logic        halt_req = 1'b0;
    logic        br_valid = 1'b0;
    logic [4:0]  br_target = '0;
    logic [4:0]  pm_addr;
    logic [31:0] pm_data;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic [31:0] ins_data;
    logic [4:0]  ins_pc;
    logic        busy;
    logic        done;

    logic [31:0] mem [32];

    int total = 0;
    int bad = 0;

    int          beats_pc[$];
    logic [31:0] beats_data[$];

    // Model: 0 idle, 1 fetching, 2 last word in flight, 3 finished
    int          m_state = 0;
    int          m_pc = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = '0;
    int          m_ipc = 0;

    fetch_ctrl #(
        .ADDR_W  (5),
        .INSTR_W (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .halt_req   (halt_req),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .pm_addr    (pm_addr),
        .pm_data    (pm_data),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_data   (ins_data),
        .ins_pc     (ins_pc),
        .busy       (busy),
        .done       (done)
    );

    assign pm_data = mem[pm_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the fetch rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_pc    <= 0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ipc   <= 0;
        end else if (halt_req) begin
            m_state <= 0;
            m_valid <= 1'b0;
        end else if (br_valid && (m_state == 1 || m_state == 2)) begin
            m_state <= 1;
            m_pc    <= int'(br_target);
            m_valid <= 1'b0;
        end else if (m_state == 0 || m_state == 3) begin
            if (start) begin
                m_state <= 1;
                m_pc    <= int'(start_addr);
            end
        end else if (m_state == 1) begin
            if (!m_valid || ins_ready) begin
                m_valid <= 1'b1;
                m_data  <= mem[m_pc];
                m_ipc   <= m_pc;
                if (m_pc == int'(end_addr)) m_state <= 2;
                else m_pc <= (m_pc + 1) % 32;
            end
        end else begin
            if (m_valid && ins_ready) begin
                m_valid <= 1'b0;
                m_state <= 3;
            end
        end
    end

    // Compare DUT to model every cycle.
    always @(negedge clk) begin
        chk("pm_addr", 32'(pm_addr), 32'(m_pc));
        chk("ins_valid", 32'(ins_valid), 32'(m_valid));
        chk("ins_data", ins_data, m_data);
        chk("ins_pc", 32'(ins_pc), 32'(m_ipc));
        chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
        chk("done", 32'(done), 32'(m_state == 3));
    end

    // Log completed handshakes once the cycle's inputs have settled.
    always @(negedge clk) begin
        #2;
        if (rst_n && ins_valid && ins_ready) begin
            beats_pc.push_back(int'(ins_pc));
            beats_data.push_back(ins_data);
        end
    end

    task automatic start_run(input logic [4:0] sa, input logic [4:0] ea);
        beats_pc.delete();
        beats_data.delete();
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = sa;
        end_addr   = ea;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (done) begin
                cycles = i;
                break;
            end
        end
        chk({name, "_done_reached"}, 32'(done), 32'd1);
    endtask

    task automatic check_beats(input string name, input int exp[$]);
        chk({name, "_beat_count"}, 32'(beats_pc.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < beats_pc.size()) begin
                chk({name, "_beat_pc"}, 32'(beats_pc[i]), 32'(exp[i]));
                chk({name, "_beat_data"}, beats_data[i], mem[exp[i]]);
            end
        end
    endtask

    initial begin
        int exp_q[$];
        int cyc;
        bit found;

        for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 17);

        // Reset values
        #2;
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pm_addr", 32'(pm_addr), 32'd0);
        #20 rst_n = 1'b1;

        // 1: straight run
        start_run(5'd0, 5'd6);
        wait_done("t1", 40, cyc);
        chk("t1_latency", 32'(cyc), 32'd9);
        exp_q = '{0, 1, 2, 3, 4, 5, 6};
        check_beats("t1", exp_q);

        // 2: back-pressure
        start_run(5'd0, 5'd6);
        repeat (2) @(posedge clk);
        #1 ins_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 ins_ready = 1'b1;
        wait_done("t2", 40, cyc);
        exp_q = '{0, 1, 2, 3, 4, 5, 6};
        check_beats("t2", exp_q);

        // 3: branch while ins_pc=4 is presented; that word is not taken
        start_run(5'd0, 5'd6);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ins_valid && ins_pc == 5'd4) found = 1'b1;
        end
        chk("t3_saw_pc4", 32'(found), 32'd1);
        #1;
        br_valid  = 1'b1;
        br_target = 5'd2;
        ins_ready = 1'b0;
        @(posedge clk); #1;
        br_valid  = 1'b0;
        ins_ready = 1'b1;
        @(negedge clk);
        chk("t3_squashed", 32'(ins_valid), 32'd0);
        wait_done("t3", 40, cyc);
        exp_q = '{0, 1, 2, 3, 2, 3, 4, 5, 6};
        check_beats("t3", exp_q);

        // 4: wrap, with a start while busy that must be ignored
        start_run(5'd30, 5'd1);
        start      = 1'b1;
        start_addr = 5'd10;
        @(posedge clk); #1;
        start      = 1'b0;
        start_addr = 5'd30;
        wait_done("t4", 40, cyc);
        exp_q = '{30, 31, 0, 1};
        check_beats("t4", exp_q);

        // 5a: halt during fetch
        start_run(5'd0, 5'd6);
        repeat (2) @(posedge clk);
        #1 halt_req = 1'b1;
        @(posedge clk); #1;
        halt_req = 1'b0;
        @(negedge clk);
        chk("t5_halt_busy", 32'(busy), 32'd0);
        chk("t5_halt_valid", 32'(ins_valid), 32'd0);
        chk("t5_halt_done", 32'(done), 32'd0);

        // 5b: asynchronous reset mid-run
        start_run(5'd0, 5'd6);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(ins_valid), 32'd0);
        chk("t5_rst_data", ins_data, 32'd0);
        chk("t5_rst_pc", 32'(ins_pc), 32'd0);
        chk("t5_rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 6a: single word
        start_run(5'd5, 5'd5);
        wait_done("t6", 20, cyc);
        exp_q = '{5};
        check_beats("t6", exp_q);

        // 6b: halt beats branch in the same cycle; pc keeps its value
        start_run(5'd0, 5'd6);
        repeat (2) @(posedge clk);
        #1;
        halt_req  = 1'b1;
        br_valid  = 1'b1;
        br_target = 5'd20;
        @(posedge clk); #1;
        halt_req  = 1'b0;
        br_valid  = 1'b0;
        @(negedge clk);
        chk("t6_prio_busy", 32'(busy), 32'd0);
        chk("t6_prio_done", 32'(done), 32'd0);
        chk("t6_prio_pc", 32'(pm_addr), 32'd2);

        // Branch while idle is ignored
        #1;
        br_valid  = 1'b1;
        br_target = 5'd9;
        @(posedge clk); #1;
        br_valid  = 1'b0;
        @(negedge clk);
        chk("idle_br_pc", 32'(pm_addr), 32'd2);
        chk("idle_br_busy", 32'(busy), 32'd0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
